// File: rtl/sdma_wdata_demux_if.sv
// Write-beat bus between the SDMA datapath and its five write destinations.
// The master modport is the demux side; slave is the surrounding environment.
interface sdma_wdata_demux_if #(
  parameter int CACHE_DW = 128,
  parameter int AHB_DW   = 32,
  parameter int PORTID_W = 3
);
  logic [PORTID_W-1:0]   i_inst_dstportid;
  logic                  i_sdma_dportwreq;
  logic                  o_sdma_dportwrdy;
  logic [CACHE_DW-1:0]   i_sdma_dportwdata;
  logic [CACHE_DW/8-1:0] i_sdma_dportwvld;

  logic                  o_sdma_ahbwreq;
  logic                  i_sdma_ahbwrdy;
  logic [AHB_DW-1:0]     o_sdma_ahbwdata;
  logic [AHB_DW/8-1:0]   o_sdma_ahbwstrb;

  logic                  o_sdma_dc1wreq, o_sdma_dc2wreq, o_sdma_wc1wreq, o_sdma_wc2wreq;
  logic                  i_sdma_dc1wrdy, i_sdma_dc2wrdy, i_sdma_wc1wrdy, i_sdma_wc2wrdy;
  logic [CACHE_DW-1:0]   o_sdma_dc1wdata, o_sdma_dc2wdata, o_sdma_wc1wdata, o_sdma_wc2wdata;
  logic [CACHE_DW/8-1:0] o_sdma_dc1wstrb, o_sdma_dc2wstrb, o_sdma_wc1wstrb, o_sdma_wc2wstrb;

  logic                  o_sdma_wdone;
  logic                  o_sdma_werr;

  modport master (
    input  i_inst_dstportid, i_sdma_dportwreq, i_sdma_dportwdata, i_sdma_dportwvld,
    input  i_sdma_ahbwrdy, i_sdma_dc1wrdy, i_sdma_dc2wrdy, i_sdma_wc1wrdy, i_sdma_wc2wrdy,
    output o_sdma_dportwrdy,
    output o_sdma_ahbwreq, o_sdma_ahbwdata, o_sdma_ahbwstrb,
    output o_sdma_dc1wreq, o_sdma_dc2wreq, o_sdma_wc1wreq, o_sdma_wc2wreq,
    output o_sdma_dc1wdata, o_sdma_dc2wdata, o_sdma_wc1wdata, o_sdma_wc2wdata,
    output o_sdma_dc1wstrb, o_sdma_dc2wstrb, o_sdma_wc1wstrb, o_sdma_wc2wstrb,
    output o_sdma_wdone, o_sdma_werr
  );

  modport slave (
    output i_inst_dstportid, i_sdma_dportwreq, i_sdma_dportwdata, i_sdma_dportwvld,
    output i_sdma_ahbwrdy, i_sdma_dc1wrdy, i_sdma_dc2wrdy, i_sdma_wc1wrdy, i_sdma_wc2wrdy,
    input  o_sdma_dportwrdy,
    input  o_sdma_ahbwreq, o_sdma_ahbwdata, o_sdma_ahbwstrb,
    input  o_sdma_dc1wreq, o_sdma_dc2wreq, o_sdma_wc1wreq, o_sdma_wc2wreq,
    input  o_sdma_dc1wdata, o_sdma_dc2wdata, o_sdma_wc1wdata, o_sdma_wc2wdata,
    input  o_sdma_dc1wstrb, o_sdma_dc2wstrb, o_sdma_wc1wstrb, o_sdma_wc2wstrb,
    input  o_sdma_wdone, o_sdma_werr
  );
endinterface

// File: rtl/sdma_wdata_demux.sv
// Steers one buffered SDMA write beat to AHB, DCACHE1/2 or WCACHE1/2.
// AHB beats are split into AHB-width lanes; lanes with no valid bytes are skipped.
module sdma_wdata_demux #(
  parameter int CACHE_DW = 128,
  parameter int AHB_DW   = 32,
  parameter int PORTID_W = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  sdma_wdata_demux_if.master bus
);
  localparam int RATIO = CACHE_DW / AHB_DW;
  localparam int CB    = CACHE_DW / 8;
  localparam int AB    = AHB_DW / 8;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {IDLE, CWR, AHBWR} state_e;

  state_e              state_q;
  logic [CACHE_DW-1:0] data_q;
  logic [CB-1:0]       vld_q;
  logic [RATIO-1:0]    mask_q, mask_d;
  logic [LW-1:0]       lane_q;
  logic [3:0]          creq_q;
  logic                ahb_req_q;
  logic [AHB_DW-1:0]   ahb_data_q;
  logic [AB-1:0]       ahb_strb_q;

  logic                c_hs, ahb_hs, final_hs, rdy, accept;
  logic                dst_ahb, dst_cache, in_zero;
  logic [3:0]          crdy, cache_oh;
  logic [RATIO-1:0]    in_mask;

  function automatic logic [RATIO-1:0] lane_mask(input logic [CB-1:0] v);
    logic [RATIO-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < RATIO; k++) m[k] = |v[k*AB +: AB];
    return m;
  endfunction

  function automatic logic [LW-1:0] low_lane(input logic [RATIO-1:0] m);
    logic [LW-1:0] r;
    logic          found;
    r = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (m[k] && !found) begin
        r = LW'(k);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [AHB_DW-1:0] lane_data(input logic [CACHE_DW-1:0] d, input logic [LW-1:0] l);
    logic [AHB_DW-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < RATIO; k++) if (l == LW'(k)) r = d[k*AHB_DW +: AHB_DW];
    return r;
  endfunction

  function automatic logic [AB-1:0] lane_strb(input logic [CB-1:0] v, input logic [LW-1:0] l);
    logic [AB-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < RATIO; k++) if (l == LW'(k)) r = v[k*AB +: AB];
    return r;
  endfunction

  assign crdy   = {bus.i_sdma_wc2wrdy, bus.i_sdma_wc1wrdy, bus.i_sdma_dc2wrdy, bus.i_sdma_dc1wrdy};
  assign c_hs   = |(creq_q & crdy);
  assign ahb_hs = ahb_req_q & bus.i_sdma_ahbwrdy;

  always_comb begin
    mask_d = mask_q;
    if (ahb_hs) mask_d[lane_q] = 1'b0;
  end

  // Ready also opens on the last handshake so a new beat can replace the old one without a bubble.
  assign final_hs = c_hs | (ahb_hs & ~|mask_d);
  assign rdy      = ~i_rst & ((state_q == IDLE) | final_hs);
  assign accept   = bus.i_sdma_dportwreq & rdy;
  assign in_zero  = ~|bus.i_sdma_dportwvld;
  assign in_mask  = lane_mask(bus.i_sdma_dportwvld);

  always_comb begin
    dst_ahb   = 1'b0;
    dst_cache = 1'b0;
    cache_oh  = '0;
    case (bus.i_inst_dstportid)
      PORTID_W'(0): dst_ahb = 1'b1;
      PORTID_W'(4), PORTID_W'(5), PORTID_W'(6), PORTID_W'(7): begin
        dst_cache = 1'b1;
        cache_oh  = 4'b0001 << bus.i_inst_dstportid[1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      data_q     <= '0;
      vld_q      <= '0;
      mask_q     <= '0;
      lane_q     <= '0;
      creq_q     <= '0;
      ahb_req_q  <= 1'b0;
      ahb_data_q <= '0;
      ahb_strb_q <= '0;
    end else if (accept) begin
      data_q     <= bus.i_sdma_dportwdata;
      vld_q      <= bus.i_sdma_dportwvld;
      state_q    <= IDLE;
      mask_q     <= '0;
      lane_q     <= '0;
      creq_q     <= '0;
      ahb_req_q  <= 1'b0;
      ahb_data_q <= '0;
      ahb_strb_q <= '0;
      if (dst_cache) begin
        state_q <= CWR;
        creq_q  <= cache_oh;
      end else if (dst_ahb && !in_zero) begin
        state_q    <= AHBWR;
        mask_q     <= in_mask;
        lane_q     <= low_lane(in_mask);
        ahb_req_q  <= 1'b1;
        ahb_data_q <= lane_data(bus.i_sdma_dportwdata, low_lane(in_mask));
        ahb_strb_q <= lane_strb(bus.i_sdma_dportwvld, low_lane(in_mask));
      end
    end else if (c_hs) begin
      state_q <= IDLE;
      creq_q  <= '0;
    end else if (ahb_hs) begin
      mask_q <= mask_d;
      if (~|mask_d) begin
        state_q    <= IDLE;
        ahb_req_q  <= 1'b0;
        ahb_data_q <= '0;
        ahb_strb_q <= '0;
      end else begin
        lane_q     <= low_lane(mask_d);
        ahb_data_q <= lane_data(data_q, low_lane(mask_d));
        ahb_strb_q <= lane_strb(vld_q, low_lane(mask_d));
      end
    end
  end

  assign bus.o_sdma_dportwrdy = rdy;
  assign bus.o_sdma_wdone = final_hs | (accept & ~dst_cache & ~(dst_ahb & ~in_zero));
  assign bus.o_sdma_werr  = accept & ~dst_cache & ~dst_ahb;

  assign bus.o_sdma_ahbwreq  = ahb_req_q;
  assign bus.o_sdma_ahbwdata = ahb_data_q;
  assign bus.o_sdma_ahbwstrb = ahb_strb_q;

  assign bus.o_sdma_dc1wreq  = creq_q[0];
  assign bus.o_sdma_dc2wreq  = creq_q[1];
  assign bus.o_sdma_wc1wreq  = creq_q[2];
  assign bus.o_sdma_wc2wreq  = creq_q[3];
  assign bus.o_sdma_dc1wdata = creq_q[0] ? data_q : '0;
  assign bus.o_sdma_dc2wdata = creq_q[1] ? data_q : '0;
  assign bus.o_sdma_wc1wdata = creq_q[2] ? data_q : '0;
  assign bus.o_sdma_wc2wdata = creq_q[3] ? data_q : '0;
  assign bus.o_sdma_dc1wstrb = creq_q[0] ? vld_q : '0;
  assign bus.o_sdma_dc2wstrb = creq_q[1] ? vld_q : '0;
  assign bus.o_sdma_wc1wstrb = creq_q[2] ? vld_q : '0;
  assign bus.o_sdma_wc2wstrb = creq_q[3] ? vld_q : '0;
endmodule

// File: tb/tb_sdma_wdata_demux.sv
// Scoreboard bench for sdma_wdata_demux: stimulus queues expected events, a negedge monitor checks them.
module tb_sdma_wdata_demux;
  logic clk, rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   nacc = 0;
  int   acc_cyc[64];
  int   nb = 0;

  typedef struct {
    int           kind;  // 0 ahb, 1 dc1, 2 dc2, 3 wc1, 4 wc2, 5 wdone, 6 werr
    logic [127:0] data;
    logic [15:0]  strb;
    int           beat;
    int           off;
  } exp_t;
  exp_t q[$];

  localparam logic [127:0] D2 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D3 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] DA = 128'hAAAA5555AAAA5555AAAA5555AAAA5555;
  localparam logic [127:0] DB = 128'h00112233445566778899AABBCCDDEEFF;

  sdma_wdata_demux_if #(.CACHE_DW(128), .AHB_DW(32), .PORTID_W(3)) bus ();
  sdma_wdata_demux #(.CACHE_DW(128), .AHB_DW(32), .PORTID_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input logic [127:0] d, input logic [15:0] s, input int beat, input int off);
    exp_t e;
    e.kind = kind; e.data = d; e.strb = s; e.beat = beat; e.off = off;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_ev(input int kind, input logic [127:0] d, input logic [15:0] s);
    exp_t e;
    int   want;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_ev: got kind=%0d data=%h at cyc %0d, required no event", kind, d, cyc);
    end else begin
      e = q.pop_front();
      want = (e.beat < nacc) ? acc_cyc[e.beat] + e.off : -1;
      if (e.kind != kind || e.data !== d || e.strb !== s || cyc != want) begin
        n_fail++;
        $display("FAIL event: got kind=%0d data=%h strb=%h cyc=%0d, required kind=%0d data=%h strb=%h cyc=%0d",
                 kind, d, s, cyc, e.kind, e.data, e.strb, want);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [4:0] reqs;
    logic       noisy;
    if (bus.i_sdma_dportwreq && bus.o_sdma_dportwrdy) begin
      if (nacc < 64) acc_cyc[nacc] = cyc;
      nacc++;
    end
    if (bus.o_sdma_ahbwreq && bus.i_sdma_ahbwrdy) check_ev(0, 128'(bus.o_sdma_ahbwdata), 16'(bus.o_sdma_ahbwstrb));
    if (bus.o_sdma_dc1wreq && bus.i_sdma_dc1wrdy) check_ev(1, bus.o_sdma_dc1wdata, bus.o_sdma_dc1wstrb);
    if (bus.o_sdma_dc2wreq && bus.i_sdma_dc2wrdy) check_ev(2, bus.o_sdma_dc2wdata, bus.o_sdma_dc2wstrb);
    if (bus.o_sdma_wc1wreq && bus.i_sdma_wc1wrdy) check_ev(3, bus.o_sdma_wc1wdata, bus.o_sdma_wc1wstrb);
    if (bus.o_sdma_wc2wreq && bus.i_sdma_wc2wrdy) check_ev(4, bus.o_sdma_wc2wdata, bus.o_sdma_wc2wstrb);
    if (bus.o_sdma_wdone) check_ev(5, '0, '0);
    if (bus.o_sdma_werr)  check_ev(6, '0, '0);

    reqs = {bus.o_sdma_ahbwreq, bus.o_sdma_dc1wreq, bus.o_sdma_dc2wreq, bus.o_sdma_wc1wreq, bus.o_sdma_wc2wreq};
    if (|reqs) begin
      n_cmp++;
      if ($countones(reqs) != 1) begin
        n_fail++;
        $display("FAIL one_req: got reqs=%b, required a single bit set", reqs);
      end
    end
    noisy = (!bus.o_sdma_ahbwreq && (bus.o_sdma_ahbwdata != '0 || bus.o_sdma_ahbwstrb != '0)) ||
            (!bus.o_sdma_dc1wreq && (bus.o_sdma_dc1wdata != '0 || bus.o_sdma_dc1wstrb != '0)) ||
            (!bus.o_sdma_dc2wreq && (bus.o_sdma_dc2wdata != '0 || bus.o_sdma_dc2wstrb != '0)) ||
            (!bus.o_sdma_wc1wreq && (bus.o_sdma_wc1wdata != '0 || bus.o_sdma_wc1wstrb != '0)) ||
            (!bus.o_sdma_wc2wreq && (bus.o_sdma_wc2wdata != '0 || bus.o_sdma_wc2wstrb != '0));
    n_cmp++;
    if (noisy) begin
      n_fail++;
      $display("FAIL quiet_ports: got nonzero data/strb on an unselected port at cyc %0d, required 0", cyc);
    end
  end

  // Called at posedge+1; returns the cycle in which the beat was accepted.
  task automatic send(input logic [2:0] id, input logic [127:0] d, input logic [15:0] v, output int n);
    logic acc;
    bus.i_inst_dstportid  = id;
    bus.i_sdma_dportwdata = d;
    bus.i_sdma_dportwvld  = v;
    bus.i_sdma_dportwreq  = 1'b1;
    n = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = bus.o_sdma_dportwrdy;
      if (acc) n = cyc;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    bus.i_sdma_dportwreq = 1'b0;
    if (n < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no accept in 20 cycles, required accept for id=%b", id);
    end
  endtask

  initial begin
    int n1, n2;
    rst = 1'b1;
    bus.i_inst_dstportid  = '0;
    bus.i_sdma_dportwreq  = 1'b0;
    bus.i_sdma_dportwdata = '0;
    bus.i_sdma_dportwvld  = '0;
    bus.i_sdma_ahbwrdy = 1'b1;
    bus.i_sdma_dc1wrdy = 1'b1;
    bus.i_sdma_dc2wrdy = 1'b1;
    bus.i_sdma_wc1wrdy = 1'b1;
    bus.i_sdma_wc2wrdy = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_reqs", 128'({bus.o_sdma_ahbwreq, bus.o_sdma_dc1wreq, bus.o_sdma_dc2wreq, bus.o_sdma_wc1wreq, bus.o_sdma_wc2wreq}), '0);
    chk("rst_ahb", 128'({bus.o_sdma_ahbwdata, bus.o_sdma_ahbwstrb}), '0);
    chk("rst_dc1", bus.o_sdma_dc1wdata | 128'(bus.o_sdma_dc1wstrb), '0);
    chk("rst_wc2", bus.o_sdma_wc2wdata | 128'(bus.o_sdma_wc2wstrb), '0);
    chk("rst_done_err", 128'({bus.o_sdma_wdone, bus.o_sdma_werr}), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 128'(bus.o_sdma_dportwrdy), 128'(1));
    @(posedge clk); #1;

    // DC1 beat, rdy low for 3 cycles: handshake and wdone 4 cycles after accept
    bus.i_sdma_dc1wrdy = 1'b0;
    push(1, D2, 16'hFFFF, nb, 4);
    push(5, '0, '0, nb, 4);
    send(3'b100, D2, 16'hFFFF, n1);
    nb++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dc1_stall_req", 128'(bus.o_sdma_dc1wreq), 128'(1));
      chk("dc1_stall_data", bus.o_sdma_dc1wdata, D2);
      chk("dc1_stall_rdy", 128'(bus.o_sdma_dportwrdy), 128'(0));
      @(posedge clk); #1;
    end
    bus.i_sdma_dc1wrdy = 1'b1;
    repeat (2) @(posedge clk); #1;

    // AHB beat vld=F0F0: lane1 then lane3
    push(0, 128'(32'hFEDCBA98), 16'h000F, nb, 1);
    push(0, 128'(32'h01234567), 16'h000F, nb, 2);
    push(5, '0, '0, nb, 2);
    send(3'b000, D3, 16'hF0F0, n1);
    nb++;
    repeat (3) @(posedge clk); #1;

    // AHB partial strobe within one lane
    push(0, 128'(32'hFEDCBA98), 16'h0003, nb, 1);
    push(5, '0, '0, nb, 1);
    send(3'b000, D3, 16'h0030, n1);
    nb++;
    repeat (2) @(posedge clk); #1;

    // AHB beat with no valid bytes: dropped, wdone in accept cycle
    push(5, '0, '0, nb, 0);
    send(3'b000, D3, 16'h0000, n1);
    nb++;
    repeat (2) @(posedge clk); #1;

    // WC1 then WC2 back to back
    push(3, DA, 16'hFFFF, nb, 1);
    push(5, '0, '0, nb, 1);
    push(4, DB, 16'h00FF, nb + 1, 1);
    push(5, '0, '0, nb + 1, 1);
    send(3'b110, DA, 16'hFFFF, n1);
    send(3'b111, DB, 16'h00FF, n2);
    nb += 2;
    chk("no_bubble", 128'(n2 - n1), 128'(1));
    repeat (3) @(posedge clk); #1;

    // DC2 beat
    push(2, D3, 16'h0F0F, nb, 1);
    push(5, '0, '0, nb, 1);
    send(3'b101, D3, 16'h0F0F, n1);
    nb++;
    repeat (2) @(posedge clk); #1;

    // illegal id: wdone + werr in accept cycle, ready stays up
    push(5, '0, '0, nb, 0);
    push(6, '0, '0, nb, 0);
    send(3'b010, D2, 16'hFFFF, n1);
    nb++;
    @(negedge clk);
    chk("illegal_rdy", 128'(bus.o_sdma_dportwrdy), 128'(1));
    @(posedge clk); #1;

    // reset after lane-0 handshake of a full AHB beat
    push(0, 128'(32'h76543210), 16'h000F, nb, 1);
    send(3'b000, D3, 16'hFFFF, n1);
    nb++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_ahbreq", 128'(bus.o_sdma_ahbwreq), 128'(0));
    chk("midrst_ahbdata", 128'(bus.o_sdma_ahbwdata), '0);
    chk("midrst_wdone", 128'(bus.o_sdma_wdone), 128'(0));
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("midrst_rdy", 128'(bus.o_sdma_dportwrdy), 128'(1));

    chk("scoreboard_drain", 128'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
